// File: rtl/enc_codeword_pipe.sv
// enc_codeword_pipe
//   Two-stage pipelined SEC-DED encoder. A data word and its codeword_width
//   mode are accepted on the input handshake. The full codeword, with the check
//   bits in the low positions and the data above them, leaves on the output
//   handshake. Every codeword it emits decodes to an all-zero syndrome.
//
//   Mode sizing (codeword_width):
//     00 -> N=8  (P=4, D=4)
//     01 -> N=16 (P=5, D=11)
//     1x -> N=32 (P=6, D=26)
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   data_in         data word, LSB-aligned; bits at and above D are ignored
//   codeword_width  mode, sampled together with data_in
//   in_valid        upstream offers a word
//   in_ready        block accepts a word this cycle
//   codeword_out    encoded word; bits at and above N are zero
//   out_width       mode that travels with codeword_out
//   out_valid       codeword_out holds a word
//   out_ready       downstream accepts
//   enc_count       saturating count of output transfers
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid, and holds its payload stable, until the
// transfer happens. in_ready is derived only from pipeline state and
// out_ready, so it never depends on in_valid.
module enc_codeword_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_in,
  input  logic [1:0]       codeword_width,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      codeword_out,
  output logic [1:0]       out_width,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] enc_count
);

  // Data bit j of a P-check-bit code uses the j-th integer, in ascending
  // order, among 1..2^(P-1)-1 whose Hamming weight is at least 2. Each check
  // bit k is the XOR of the data bits whose column has bit k set. The loop
  // walks the candidate columns and keeps a running data index, so it unrolls
  // to a fixed XOR tree for every constant P.
  function automatic logic [4:0] check_bits(input int p, input logic [25:0] d);
    logic [4:0] acc;
    logic [4:0] j;
    acc = '0;
    j   = '0;
    for (int v = 3; v < 32; v++) begin
      if ((v < (1 << (p - 1))) && ($countones(v[4:0]) >= 2)) begin
        if (d[j]) acc = acc ^ v[4:0];
        j = j + 5'd1;
      end
    end
    return acc;
  endfunction

  // ---------------- input-side combinational encode ----------------
  logic [25:0] data_m;
  logic [4:0]  chk_c;

  always_comb begin
    data_m = '0;
    chk_c  = '0;
    if (codeword_width[1]) begin
      data_m = data_in[25:0];
      chk_c  = check_bits(6, data_m);
    end else if (codeword_width[0]) begin
      data_m = {15'b0, data_in[10:0]};
      chk_c  = check_bits(5, data_m);
    end else begin
      data_m = {22'b0, data_in[3:0]};
      chk_c  = check_bits(4, data_m);
    end
  end

  // ---------------- pipeline control ----------------
  logic        s1_valid;
  logic [1:0]  s1_mode;
  logic [25:0] s1_data;
  logic [4:0]  s1_chk;
  logic        s2_adv;
  logic        in_fire;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // ---------------- S2 combinational assembly ----------------
  // Data bits above D and unused check positions are zero, so XOR-reducing
  // the whole stage gives the parity for every mode.
  logic        par_c;
  logic [31:0] cw_c;

  always_comb begin
    par_c = (^s1_data) ^ (^s1_chk);
    cw_c  = '0;
    if (s1_mode[1]) begin
      cw_c = {s1_data, par_c, s1_chk};
    end else if (s1_mode[0]) begin
      cw_c = {16'b0, s1_data[10:0], par_c, s1_chk[3:0]};
    end else begin
      cw_c = {24'b0, s1_data[3:0], par_c, s1_chk[2:0]};
    end
  end

  // ---------------- stage 1 ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_data  <= '0;
      s1_chk   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_mode <= codeword_width;
        s1_data <= data_m;
        s1_chk  <= chk_c;
      end
    end
  end

  // ---------------- stage 2 / outputs ----------------
  // Payload registers load only when a real word moves in. Bubbles clear
  // out_valid but leave the last codeword in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      codeword_out <= '0;
      out_width    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        codeword_out <= cw_c;
        out_width    <= s1_mode;
      end
    end
  end

  // ---------------- saturating transfer counter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
    end else if (out_valid && out_ready && (enc_count != '1)) begin
      enc_count <= enc_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_enc_codeword_pipe.sv
// Self-checking bench for enc_codeword_pipe. The reference model builds the
// code columns from their definition, places check and data bits, and sets
// even overall parity. A separate syndrome calculator checks that every
// emitted codeword decodes cleanly.
module tb_enc_codeword_pipe;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      data_in;
  logic [1:0]       codeword_width;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      codeword_out;
  logic [1:0]       out_width;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] enc_count;

  enc_codeword_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .codeword_width(codeword_width),
    .in_valid(in_valid), .in_ready(in_ready), .codeword_out(codeword_out),
    .out_width(out_width), .out_valid(out_valid), .out_ready(out_ready),
    .enc_count(enc_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [33:0] exp_q[$];
  int          out_cyc[$];
  int          out_cnt  = 0;
  int          acc_cnt  = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int p_of(input logic [1:0] mode);
    return mode[1] ? 6 : (mode[0] ? 5 : 4);
  endfunction

  function automatic logic [33:0] model(input logic [1:0] mode, input logic [31:0] din);
    int p;
    int syn;
    int cols[$];
    logic [31:0] cw;
    p = p_of(mode);
    for (int v = 1; v < (1 << (p - 1)); v++)
      if ($countones(v) >= 2) cols.push_back(v);
    syn = 0;
    cw  = '0;
    for (int j = 0; j < cols.size(); j++)
      if (din[j]) begin
        syn = syn ^ cols[j];
        cw[p + j] = 1'b1;
      end
    for (int k = 0; k < p - 1; k++) cw[k] = syn[k];
    cw[p - 1] = (($countones(cw) & 1) != 0);
    return {mode, cw};
  endfunction

  // Decoder view: every column carries the overall-parity row at bit P-1.
  // Returns 32'hDEAD when bits outside the codeword are set.
  function automatic logic [31:0] syndrome(input logic [1:0] mode, input logic [31:0] cw);
    int p;
    int n;
    int syn;
    int cols[$];
    logic above;
    p = p_of(mode);
    for (int v = 1; v < (1 << (p - 1)); v++)
      if ($countones(v) >= 2) cols.push_back(v);
    n = p + cols.size();
    syn = 0;
    above = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (cw[i]) begin
        if (i >= n)          above = 1'b1;
        else if (i < p - 1)  syn = syn ^ ((1 << i) | (1 << (p - 1)));
        else if (i == p - 1) syn = syn ^ (1 << (p - 1));
        else                 syn = syn ^ (cols[i - p] | (1 << (p - 1)));
      end
    end
    return above ? 32'hDEAD : syn;
  endfunction

  // ---------------- driver / monitor ----------------
  // Sample at the falling edge, then move inputs 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_width, codeword_out}, prev_out);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else chk("codeword", {out_width, codeword_out}, exp_q.pop_front());
        chk("syndrome", syndrome(out_width, codeword_out), 0);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(codeword_width, data_in));
        acc_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_width, codeword_out};
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    out_cyc.delete();
    out_cnt = 0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    step();
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [1:0] mode, input logic [31:0] d,
                          input logic [31:0] exp_cw);
    codeword_width = mode;
    data_in   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    data_in  = $urandom;
    step();
    chk({tag, "_lat"}, out_valid, 1);
    chk(tag, codeword_out, exp_cw);
    chk({tag, "_w"}, out_width, mode);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int out0;
    int sat;
    rst = 1'b1;
    data_in = '0;
    codeword_width = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_codeword", codeword_out, 0);
    chk("rst_out_width", out_width, 0);
    chk("rst_enc_count", enc_count, 0);
    chk("rst_in_ready", in_ready, 1);

    directed("m8_one",    2'b00, 32'h00000001, 32'h0000001B);
    directed("m16_one",   2'b01, 32'h00000001, 32'h00000033);
    directed("m16_full",  2'b01, 32'h000007FF, 32'h0000FFFF);
    directed("m32_full",  2'b10, 32'h03FFFFFF, 32'hFFFFFFFF);
    directed("m32_upper", 2'b11, 32'hFC000000, 32'h00000000);
    drain();

    // Back-to-back mixed-mode stream.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      codeword_width = 2'($urandom_range(0, 3));
      data_in = $urandom;
      step();
    end
    drain();
    chk("stream_count", out_cyc.size(), 8);
    if (out_cyc.size() == 8) chk("stream_gapless", out_cyc[7] - out_cyc[0], 7);
    chk("stream_enc_count", enc_count, 8);

    // Backpressure: two words fill the pipe, then the input stalls.
    base = acc_cnt;
    out0 = out_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      codeword_width = 2'($urandom_range(0, 3));
      data_in = $urandom;
      step();
    end
    chk("bp_accepted", acc_cnt - base, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    drain();
    chk("bp_delivered", out_cnt - out0, 2);

    // Reset with two words in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      codeword_width = 2'($urandom_range(0, 3));
      data_in = $urandom;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_enc_count", enc_count, 0);
    rst = 1'b0;
    exp_q.delete();
    out_cyc.delete();
    out_cnt = 0;
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("no_stale_word", out_cnt, 0);

    // Random soak; long enough to saturate the narrow counter.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 70);
      codeword_width = 2'($urandom_range(0, 3));
      data_in = $urandom;
      step();
    end
    drain();
    sat = (out_cnt > 15) ? 15 : out_cnt;
    chk("soak_enc_count", enc_count, sat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
